viterbi_ctrl: RTL
=================

VITERBI_CTRL -- requirements
Module: viterbi_ctrl

Interface
REQ-001 Parameter: FRAME_LEN, default 64, number of received symbol pairs per decoded frame (legal range 2..2^ADDR_W).
REQ-002 Parameter: ADDR_W, default 6, path-memory address width.
REQ-003 Port: clk  input  1  the block's single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: flush  input  1  synchronous abort of the current frame.
REQ-006 Port: sym_valid  input  1  a symbol pair is presented to the branch-metric units.
REQ-007 Port: sym_ready  output  1  controller accepts the symbol this cycle.
REQ-008 Port: metric_clr  output  1  clear all path metrics to their start value.
REQ-009 Port: acs_en  output  1  enable ACS update and path-memory write for the accepted symbol.
REQ-010 Port: wr_addr  output  ADDR_W  path-memory write address for the accepted symbol.
REQ-011 Port: tb_start  output  1  traceback unit loads the best end state.
REQ-012 Port: tb_en  output  1  traceback read/step enable.
REQ-013 Port: rd_addr  output  ADDR_W  path-memory read address.
REQ-014 Port: dec_valid  output  1  decoded bit from the traceback unit is valid.
REQ-015 Port: dec_idx  output  ADDR_W  symbol index of the decoded bit.
REQ-016 Port: frame_done  output  1  one-cycle pulse at frame end.
REQ-017 Port: frame_cnt  output  8  count of completed frames.

Function
REQ-018 The FSM SHALL have states CLR, ACS, TB and DONE.
REQ-019 CLR SHALL last exactly one cycle with metric_clr=1 and sym_ready=0, then go to ACS.
REQ-020 In ACS, sym_ready SHALL be 1 (combinationally forced 0 when flush=1); a symbol is accepted when sym_valid and sym_ready are both 1.
REQ-021 acs_en SHALL equal sym_valid & sym_ready (combinational, same cycle); wr_addr SHALL equal the internal symbol counter sym_cnt.
REQ-022 On acceptance, sym_cnt SHALL increment; on acceptance with sym_cnt=FRAME_LEN-1, sym_cnt SHALL go to 0, tb_cnt SHALL load FRAME_LEN-1 and the FSM SHALL go to TB.
REQ-023 Gaps (sym_valid=0) in ACS SHALL stall with no counter change and acs_en=0.
REQ-024 In TB: tb_en=1 every cycle, rd_addr=tb_cnt, tb_start=1 only in the first TB cycle (rd_addr=FRAME_LEN-1), tb_cnt decrements each cycle.
REQ-025 TB SHALL last exactly FRAME_LEN cycles; in the cycle with tb_cnt=0 the FSM SHALL go to DONE; tb_cnt holds 0 outside TB.
REQ-026 dec_valid and dec_idx SHALL be tb_en and rd_addr registered by one cycle (one-cycle path-memory read latency); there is no output backpressure.
REQ-027 DONE SHALL last one cycle: frame_done=1, frame_cnt increments (wraps 255->0), then go to CLR.
REQ-028 Frame period SHALL be 2*FRAME_LEN+2 cycles with sym_valid held at 1.
REQ-029 sym_valid outside ACS SHALL be ignored (sym_ready=0, acs_en=0).
REQ-030 flush=1 in any state SHALL, at the next edge, force the FSM to CLR and clear sym_cnt, tb_cnt, dec_valid and dec_idx; frame_cnt SHALL be unchanged and frame_done SHALL not pulse.
REQ-031 flush during DONE SHALL take priority: no frame_cnt increment.

Reset
REQ-032 While rst=1 and after release: state CLR, metric_clr=1, sym_ready=0, acs_en=0, wr_addr=0, tb_start=0, tb_en=0, rd_addr=0, dec_valid=0, dec_idx=0, frame_done=0, frame_cnt=0.
REQ-033 rst asserted mid-frame SHALL take effect immediately, independent of clk.

Verification
REQ-034 FRAME_LEN=4, reset release, sym_valid=1 continuously -> metric_clr 1 cycle; acs_en 4 cycles with wr_addr 0,1,2,3; tb_en 4 cycles with rd_addr 3,2,1,0 and tb_start with 3; dec_valid on next 4 cycles with dec_idx 3,2,1,0; frame_done 1 cycle; frame_cnt=1; period 10 cycles.
REQ-035 FRAME_LEN=4, sym_valid toggling 1,0,1,0... -> wr_addr advances only on accepted cycles; TB entered after the 4th acceptance.
REQ-036 flush asserted together with sym_valid at wr_addr=2 -> acs_en=0 that cycle, next cycle CLR with metric_clr=1, wr_addr=0, frame_cnt unchanged.
REQ-037 flush in second TB cycle -> dec_valid=0 the next cycle, no frame_done, FSM back to ACS after one CLR cycle.
REQ-038 Run 256 frames -> frame_cnt wraps to 0; rst asserted mid-TB -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/viterbi_ctrl.sv
// Viterbi decoder frame controller.
// Sequences one frame as: clear path metrics, accept FRAME_LEN symbol pairs
// into the ACS units and path memory, trace back through the path memory,
// then pulse frame_done and count the frame.
module viterbi_ctrl #(
    parameter int FRAME_LEN = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              sym_valid,
    output logic              sym_ready,
    output logic              metric_clr,
    output logic              acs_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              tb_start,
    output logic              tb_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              dec_valid,
    output logic [ADDR_W-1:0] dec_idx,
    output logic              frame_done,
    output logic [7:0]        frame_cnt
);

    // Index of the last symbol of a frame; traceback starts here.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    typedef enum logic [1:0] {
        CLR  = 2'd0,
        ACS  = 2'd1,
        TB   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] sym_cnt;
    logic [ADDR_W-1:0] tb_cnt;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the state-derived control outputs.
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        metric_clr = 1'b0;
        sym_ready  = 1'b0;
        tb_en      = 1'b0;
        tb_start   = 1'b0;
        frame_done = 1'b0;

        case (state)
            CLR: begin
                metric_clr = 1'b1;
                state_nxt  = ACS;
            end
            ACS: begin
                sym_ready = ~flush;
                if (sym_valid && !flush && sym_cnt == LAST_IDX) begin
                    state_nxt = TB;
                end
            end
            TB: begin
                tb_en    = 1'b1;
                tb_start = (tb_cnt == LAST_IDX);
                if (tb_cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done = ~flush;
                state_nxt  = CLR;
            end
            default: state_nxt = CLR;
        endcase

        // Abort wins over every other transition, including the DONE exit.
        if (flush) begin
            state_nxt = CLR;
        end
    end

    assign acs_en  = sym_valid & sym_ready;
    assign wr_addr = sym_cnt;
    assign rd_addr = tb_cnt;

    // Symbol (write) and traceback (read) address counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_cnt <= '0;
            tb_cnt  <= '0;
        end else if (flush) begin
            sym_cnt <= '0;
            tb_cnt  <= '0;
        end else begin
            if (acs_en) begin
                if (sym_cnt == LAST_IDX) begin
                    sym_cnt <= '0;
                    tb_cnt  <= LAST_IDX;
                end else begin
                    sym_cnt <= sym_cnt + ONE;
                end
            end
            // Counts down to zero and parks there until the next frame loads it.
            if (state == TB && tb_cnt != '0) begin
                tb_cnt <= tb_cnt - ONE;
            end
        end
    end

    // Decoded-bit qualifiers trail the read address by the path-memory latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_valid <= 1'b0;
            dec_idx   <= '0;
        end else if (flush) begin
            dec_valid <= 1'b0;
            dec_idx   <= '0;
        end else begin
            dec_valid <= tb_en;
            dec_idx   <= rd_addr;
        end
    end

    // Completed-frame counter, wrapping naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule
